// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests, exception
// info and debug pulses in; freeze/redirect/status out.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic        halt_req;
  logic        resume_req;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        halted;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype, cp0_epc,
    output halt_req, resume_req,
    input  stall, flush, new_pc, halted,
    input  stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype, cp0_epc,
    input  halt_req, resume_req,
    output stall, flush, new_pc, halted,
    output stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush arbitration, debug halt,
// stall watchdog and perf counters. Ports: clk, rst, bus.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
  parameter logic [15:0] STALL_LIMIT = 16'd1024
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] ERET = 32'h0000000e;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        pend_eff;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] sc_q, sc_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] run_q, run_d;
  logic        to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      sc_q    <= '0;
      fc_q    <= '0;
      run_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sc_q    <= sc_d;
      fc_q    <= fc_d;
      run_q   <= run_d;
      to_q    <= to_d;
    end
  end

  // A halt request seen this cycle counts as pending.
  assign pend_eff = pend_q | bus.halt_req;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    stall   = '0;
    flush   = 1'b0;
    new_pc  = '0;
    unique case (state_q)
      RUN: begin
        if (bus.excepttype != '0) begin
          flush   = 1'b1;
          new_pc  = (bus.excepttype == ERET)
                  ? bus.cp0_epc : EXC_VECTOR;
          state_d = FLUSH;
          pend_d  = pend_eff;
        end else begin
          if (bus.stallreq_mem)
            stall = 6'b011111;
          else if (bus.stallreq_ex)
            stall = 6'b001111;
          else if (bus.stallreq_id)
            stall = 6'b000111;
          if (pend_eff) begin
            state_d = HALT;
            pend_d  = 1'b0;
          end
        end
      end
      FLUSH: begin
        state_d = pend_eff ? HALT : RUN;
        pend_d  = 1'b0;
      end
      HALT: begin
        stall = 6'b111111;
        if (bus.resume_req) begin
          state_d = RUN;
          pend_d  = bus.halt_req;
        end
      end
      default: begin
        state_d = RUN;
        pend_d  = 1'b0;
      end
    endcase
    if (rst) begin
      stall  = '0;
      flush  = 1'b0;
      new_pc = '0;
    end
  end

  always_comb begin
    sc_d  = sc_q + {31'd0, (stall != '0)};
    fc_d  = fc_q;
    if (flush && fc_q != 16'hFFFF)
      fc_d = fc_q + 16'd1;
    run_d = run_q;
    // Watchdog run length is frozen while halted.
    if (state_q != HALT) begin
      if (stall == '0)
        run_d = '0;
      else if (run_q >= STALL_LIMIT)
        run_d = STALL_LIMIT;
      else
        run_d = run_q + 16'd1;
    end
    to_d = to_q | (run_d == STALL_LIMIT);
  end

  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.halted        = (state_q == HALT) & ~rst;
  assign bus.stall_timeout = to_q;
  assign bus.stall_cycles  = sc_q;
  assign bus.flush_count   = fc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reference model
// compared every cycle plus directed literal checks.
module tb_pipe_ctrl;
  localparam int LIM = 4;
  localparam logic [31:0] VEC = 32'h00000020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   go  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .EXC_VECTOR (VEC),
    .STALL_LIMIT(16'(LIM))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // model state: mode 0=run 1=flush 2=halt
  int          m_mode = 0;
  bit          m_pend = 0;
  bit          m_to   = 0;
  int unsigned m_sc   = 0;
  int          m_fc   = 0;
  int          m_run  = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic void expect_now(
    output logic [5:0]  s,
    output logic        f,
    output logic [31:0] pc);
    s = 0; f = 0; pc = 0;
    if (rst) return;
    if (m_mode == 2) s = 6'd63;
    else if (m_mode == 0) begin
      if (bus.excepttype != 0) begin
        f  = 1;
        pc = (bus.excepttype == 32'he)
           ? bus.cp0_epc : VEC;
      end else if (bus.stallreq_mem) s = 6'd31;
      else if (bus.stallreq_ex) s = 6'd15;
      else if (bus.stallreq_id) s = 6'd7;
    end
  endfunction

  always @(posedge clk) begin : model
    logic [5:0]  s;
    logic        f;
    logic [31:0] pc;
    bit          pe;
    expect_now(s, f, pc);
    if (rst) begin
      m_mode = 0; m_pend = 0; m_to = 0;
      m_sc = 0; m_fc = 0; m_run = 0;
    end else begin
      if (s != 0) m_sc = m_sc + 1;
      if (f && m_fc < 65535) m_fc++;
      if (m_mode != 2) begin
        if (s != 0)
          m_run = (m_run + 1 > LIM) ? LIM : m_run + 1;
        else
          m_run = 0;
        if (m_run == LIM) m_to = 1;
      end
      pe = m_pend | bus.halt_req;
      case (m_mode)
        0: if (bus.excepttype != 0) begin
             m_mode = 1; m_pend = pe;
           end else if (pe) begin
             m_mode = 2; m_pend = 0;
           end
        1: begin m_mode = pe ? 2 : 0; m_pend = 0; end
        default: if (bus.resume_req) begin
             m_mode = 0; m_pend = bus.halt_req;
           end
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic [5:0]  s;
    logic        f;
    logic [31:0] pc;
    if (go) begin
      expect_now(s, f, pc);
      chk("m_stall", 32'(bus.stall), 32'(s));
      chk("m_flush", 32'(bus.flush), 32'(f));
      chk("m_new_pc", bus.new_pc, pc);
      chk("m_halted", 32'(bus.halted),
          32'(!rst && m_mode == 2));
      chk("m_timeout", 32'(bus.stall_timeout), 32'(m_to));
      chk("m_stall_cycles", bus.stall_cycles, m_sc);
      chk("m_flush_count", 32'(bus.flush_count),
          32'(m_fc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nck();
    @(negedge clk);
  endtask

  initial begin
    bus.stallreq_id  = 0;
    bus.stallreq_ex  = 0;
    bus.stallreq_mem = 0;
    bus.excepttype   = 0;
    bus.cp0_epc      = 0;
    bus.halt_req     = 0;
    bus.resume_req   = 0;
    cyc();
    go = 1;
    nck();
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_sc", bus.stall_cycles, 0);
    chk("rst_fc", 32'(bus.flush_count), 0);
    cyc();
    rst = 0;

    // ex+id stall for three cycles
    bus.stallreq_ex = 1;
    bus.stallreq_id = 1;
    repeat (3) begin
      nck();
      chk("ex_stall", 32'(bus.stall), 32'h0f);
      cyc();
    end
    bus.stallreq_ex = 0;
    bus.stallreq_id = 0;
    nck();
    chk("ex_sc", bus.stall_cycles, 3);
    cyc();

    // syscall beats mem stall
    bus.excepttype   = 32'h8;
    bus.stallreq_mem = 1;
    nck();
    chk("sys_flush", 32'(bus.flush), 1);
    chk("sys_pc", bus.new_pc, 32'h20);
    chk("sys_stall", 32'(bus.stall), 0);
    cyc();
    nck();
    chk("bub_flush", 32'(bus.flush), 0);
    chk("bub_stall", 32'(bus.stall), 0);
    chk("bub_fc", 32'(bus.flush_count), 1);
    cyc();
    bus.excepttype   = 0;
    bus.stallreq_mem = 0;

    // eret
    bus.excepttype = 32'he;
    bus.cp0_epc    = 32'h0000_1234;
    nck();
    chk("eret_pc", bus.new_pc, 32'h1234);
    chk("eret_flush", 32'(bus.flush), 1);
    cyc();
    bus.excepttype = 0;
    nck();
    chk("eret_flush2", 32'(bus.flush), 0);
    chk("eret_fc", 32'(bus.flush_count), 2);
    cyc();

    // halt with overflow in same cycle
    bus.halt_req   = 1;
    bus.excepttype = 32'hc;
    nck();
    chk("ovf_flush", 32'(bus.flush), 1);
    chk("ovf_pc", bus.new_pc, 32'h20);
    cyc();
    bus.halt_req   = 0;
    bus.excepttype = 0;
    nck();
    chk("ovf_bub_h", 32'(bus.halted), 0);
    cyc();
    bus.excepttype   = 32'h8;
    bus.stallreq_mem = 1;
    nck();
    chk("halt_h", 32'(bus.halted), 1);
    chk("halt_stall", 32'(bus.stall), 32'h3f);
    chk("halt_flush", 32'(bus.flush), 0);
    cyc();
    bus.resume_req = 1;
    nck();
    chk("res_h", 32'(bus.halted), 1);
    cyc();
    bus.resume_req   = 0;
    bus.excepttype   = 0;
    bus.stallreq_mem = 0;
    nck();
    chk("res_run_h", 32'(bus.halted), 0);
    chk("res_run_s", 32'(bus.stall), 0);
    cyc();

    // halt+resume together: one run cycle
    bus.halt_req = 1;
    nck();
    chk("h2_pre", 32'(bus.halted), 0);
    cyc();
    bus.halt_req = 0;
    nck();
    chk("h2_in", 32'(bus.halted), 1);
    cyc();
    bus.halt_req   = 1;
    bus.resume_req = 1;
    cyc();
    bus.halt_req   = 0;
    bus.resume_req = 0;
    nck();
    chk("hr_run", 32'(bus.halted), 0);
    cyc();
    nck();
    chk("hr_rehalt", 32'(bus.halted), 1);
    bus.resume_req = 1;
    cyc();
    bus.resume_req = 0;

    // resume outside halt, priority
    bus.resume_req  = 1;
    bus.stallreq_id = 1;
    nck();
    chk("id_stall", 32'(bus.stall), 32'h07);
    cyc();
    bus.resume_req   = 0;
    bus.stallreq_mem = 1;
    bus.stallreq_ex  = 1;
    nck();
    chk("mem_stall", 32'(bus.stall), 32'h1f);
    cyc();
    bus.stallreq_mem = 0;
    nck();
    chk("pri_ex", 32'(bus.stall), 32'h0f);
    cyc();
    bus.stallreq_ex = 0;
    bus.stallreq_id = 0;
    cyc();

    // watchdog
    bus.stallreq_id = 1;
    repeat (LIM) begin
      nck();
      chk("wd_pre", 32'(bus.stall_timeout), 0);
      cyc();
    end
    bus.stallreq_id = 0;
    nck();
    chk("wd_set", 32'(bus.stall_timeout), 1);
    repeat (3) cyc();
    nck();
    chk("wd_sticky", 32'(bus.stall_timeout), 1);
    rst = 1;
    cyc();
    rst = 0;
    nck();
    chk("wd_clr", 32'(bus.stall_timeout), 0);
    chk("wd_sc", bus.stall_cycles, 0);
    cyc();

    // reset during halt
    bus.halt_req = 1;
    cyc();
    bus.halt_req = 0;
    repeat (10) cyc();
    rst = 1;
    nck();
    chk("hr_sc10", bus.stall_cycles, 10);
    chk("hr_rst_h", 32'(bus.halted), 0);
    chk("hr_rst_s", 32'(bus.stall), 0);
    cyc();
    rst = 0;
    nck();
    chk("post_h", 32'(bus.halted), 0);
    chk("post_s", 32'(bus.stall), 0);
    chk("post_sc", bus.stall_cycles, 0);
    cyc();
    cyc();
    go = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h00000020, target PC for every exception except eret.
REQ-002 Parameter STALL_LIMIT, default 16'd1024, consecutive stall cycles that trigger the watchdog.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 stallreq_id / stallreq_ex / stallreq_mem  in  1 each  stall requests from the ID, EX and MEM stages.
REQ-006 excepttype  in  32  exception code from MEM: 0 none, 0x1 interrupt, 0x8 syscall, 0xa invalid instruction, 0xd trap, 0xc overflow, 0xe eret.
REQ-007 cp0_epc  in  32  return address for eret.
REQ-008 halt_req / resume_req  in  1 each  debug halt and resume pulses.
REQ-009 stall  out  6  freeze vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-010 flush  out  1  clears all pipeline registers at the next edge.
REQ-011 new_pc  out  32  redirect target, valid while flush=1.
REQ-012 halted  out  1  high while in HALT.
REQ-013 stall_timeout  out  1  sticky watchdog flag.
REQ-014 stall_cycles  out  32  count of cycles with stall!=0.
REQ-015 flush_count  out  16  count of flush cycles.

Function
REQ-016 FSM states: RUN, FLUSH, HALT; state register updates only on the clock edge.
REQ-017 In RUN, stall, flush and new_pc are combinational from the inputs with zero-cycle latency.
REQ-018 In RUN, priority is excepttype!=0 > stallreq_mem > stallreq_ex > stallreq_id > none.
REQ-019 Exception in RUN drives flush=1 and stall=6'b000000.
  - new_pc=cp0_epc if excepttype=0xe, else EXC_VECTOR.
  - Any other nonzero excepttype also selects EXC_VECTOR.
  - Next state is FLUSH.
REQ-020 Stall vectors in RUN:
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - none -> 6'b000000
  - flush=0 and new_pc=0 in all of these cases.
REQ-021 FLUSH lasts exactly one cycle.
  - flush=0, stall=6'b000000, new_pc=0.
  - Stall requests and excepttype are ignored (bubble cycle).
  - Next state is HALT if halt_pending, else RUN.
REQ-022 halt_req sets halt_pending.
  - From RUN, entry to HALT occurs at the first edge where excepttype=0; halt_pending then clears.
  - If excepttype!=0 in that cycle, the exception is taken first and HALT follows FLUSH.
REQ-023 HALT drives stall=6'b111111, flush=0 and halted=1; all request and exception inputs are ignored.
REQ-024 resume_req in HALT moves to RUN at the next edge; resume_req outside HALT has no effect.
REQ-025 Simultaneous halt_req and resume_req in HALT: resume is taken and halt_pending is set, so HALT is re-entered after one RUN cycle.
REQ-026 stall_cycles increments by 1 each cycle stall!=0 (including HALT) and wraps at 2^32-1 to 0.
REQ-027 flush_count increments by 1 each cycle flush=1 and saturates at 16'hFFFF.
REQ-028 Consecutive-stall counter (16 bits):
  - Counts cycles with stall!=0 while not halted.
  - Clears on any cycle with stall=0, and is held (not cleared) in HALT.
  - Saturates at STALL_LIMIT.
  - stall_timeout sets on the edge at which the counter reaches STALL_LIMIT and stays set until rst.

Reset
REQ-029 rst applied on a rising edge forces the following regardless of state, including mid-FLUSH and mid-HALT:
  - state=RUN, halt_pending=0, stall_timeout=0
  - stall_cycles=0, flush_count=0, consecutive counter=0
REQ-030 While rst=1, outputs are stall=0, flush=0, new_pc=0 and halted=0.

Verification
REQ-031 stallreq_ex=1 and stallreq_id=1 for 3 cycles -> stall=6'b001111 for 3 cycles, stall_cycles=3.
REQ-032 excepttype=0x8 with stallreq_mem=1 -> same cycle flush=1, new_pc=32'h00000020, stall=0; next cycle flush=0; flush_count=1.
REQ-033 excepttype=0xe, cp0_epc=32'h0000_1234 -> new_pc=32'h0000_1234, flush=1 for one cycle.
REQ-034 halt_req in the same cycle as excepttype=0xc -> flush, one FLUSH cycle, then halted=1 and stall=6'b111111; resume_req -> RUN on the next edge.
REQ-035 stallreq_id held for STALL_LIMIT=4 cycles -> stall_timeout=1 after the 4th cycle; it stays 1 after the stall drops, and clears only on rst.
REQ-036 rst asserted while in HALT with stall_cycles=10 -> next cycle halted=0, stall=0, stall_cycles=0.
